// File: rtl/vfmau_booth_iter_mult_ctrl_pkg.sv
// Shared types and widths for the vfmau iterative radix-4 Booth multiplier.
package vfmau_booth_pkg;

   localparam int BOOTH_GRPS = 27;
   localparam int MANT_W     = 53;
   localparam int ACC_W      = 108;
   localparam int PP_W       = 56;
   localparam int MREG_W     = 56;

   typedef logic [2:0] booth_code_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/vfmau_booth_iter_mult_ctrl_chk.sv
// Property checker for the Booth sequencer: the accumulator guard bits must be
// clear whenever a product is being presented.
module vfmau_booth_iter_mult_ctrl_chk (
   input logic       clk,
   input logic       rst_n,
   input logic       done,
   input logic [1:0] acc_hi
);

   acc_hi_zero_a: assert property (@(posedge clk) disable iff (!rst_n) done |-> (acc_hi == 2'b00))
      else $error("accumulator guard bits set in DONE");

endmodule

// File: rtl/vfmau_booth_pp_sel.sv
// One radix-4 Booth digit select: 3-bit code and 54-bit multiplicand give a
// 56-bit two's complement partial product in {0, +A, +2A, -A, -2A}.
module vfmau_booth_pp_sel
   import vfmau_booth_pkg::*;
(
   input  booth_code_t       code,
   input  logic [MANT_W:0]   mcand,
   output logic [PP_W-1:0]   pp
);

   logic [PP_W-1:0] pos1_s;
   logic [PP_W-1:0] pos2_s;

   assign pos1_s = {2'b00, mcand};
   assign pos2_s = {1'b0, mcand, 1'b0};

   // Digit decode over {b[2k+1], b[2k], b[2k-1]}
   always_comb begin
      pp = {PP_W{1'b0}};
      case (code)
         3'b001, 3'b010: pp = pos1_s;
         3'b011:         pp = pos2_s;
         3'b100:         pp = ~pos2_s + 56'd1;
         3'b101, 3'b110: pp = ~pos1_s + 56'd1;
         default:        pp = {PP_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/vfmau_booth_iter_mult_ctrl.sv
// Iterative radix-4 Booth multiplier sequencer (53x53 -> 106, GRP_PER_CYC digits per cycle).
// Optional build macro VFMAU_BOOTH_EARLY_TERM_EN: finish as soon as the remaining multiplier digits are all zero.
module vfmau_booth_iter_mult_ctrl
   import vfmau_booth_pkg::*;
#(
   parameter int GRP_PER_CYC = 3,
   parameter int TAG_W       = 4
)(
   input  logic                  cpuclk,
   input  logic                  cpurst_b,
   input  logic                  mult_flush,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic [MANT_W-1:0]     in_src_a,
   input  logic [MANT_W-1:0]     in_src_b,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [2*MANT_W-1:0]   out_prod,
   output logic [TAG_W-1:0]      out_tag,
   output logic                  busy
);

   localparam logic [4:0] GRP_CNT  = 5'(GRP_PER_CYC);
   localparam logic [4:0] LAST_CNT = 5'(BOOTH_GRPS - GRP_PER_CYC);
   localparam int         SHIFT    = 2 * GRP_PER_CYC;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [MANT_W:0]        a54_r;
   logic [MREG_W-1:0]      mreg_r;
   logic [4:0]             cnt_r;
   logic [ACC_W-1:0]       acc_r;
   logic [TAG_W-1:0]       tag_r;
   logic [2*MANT_W-1:0]    out_prod_r;
   logic [TAG_W-1:0]       out_tag_r;

   logic [PP_W-1:0]        pp_s [GRP_PER_CYC];
   logic [ACC_W-1:0]       acc_sum_s;
   logic [MREG_W-1:0]      mreg_shift_s;
   logic                   last_s;

   for (genvar k = 0; k < GRP_PER_CYC; k++) begin : g_pp
      vfmau_booth_pp_sel u_pp_sel (
         .code  (mreg_r[2*k+2 -: 3]),
         .mcand (a54_r),
         .pp    (pp_s[k])
      );
   end

   // Sign-extend each digit's partial product and add it at weight 4^(cnt+k)
   always_comb begin
      acc_sum_s = acc_r;
      for (int k = 0; k < GRP_PER_CYC; k++) begin
         acc_sum_s = acc_sum_s +
            ({{(ACC_W-PP_W){pp_s[k][PP_W-1]}}, pp_s[k]} << ({1'b0, cnt_r, 1'b0} + 7'(2*k)));
      end
   end

   assign mreg_shift_s = mreg_r >> SHIFT;

`ifdef VFMAU_BOOTH_EARLY_TERM_EN
   assign last_s = (cnt_r == LAST_CNT) || (mreg_shift_s == {MREG_W{1'b0}});
`else
   assign last_s = (cnt_r == LAST_CNT);
`endif

   // Next-state logic; flush overrides every other input
   always_comb begin
      state_nxt_s = state_r;
      if (mult_flush) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_nxt_s = in_vld  ? RUN  : IDLE;
            RUN:     state_nxt_s = last_s  ? DONE : RUN;
            DONE:    state_nxt_s = out_rdy ? IDLE : DONE;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand latch, multiplier shifter, counter, accumulator and result registers
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         a54_r      <= {(MANT_W+1){1'b0}};
         mreg_r     <= {MREG_W{1'b0}};
         cnt_r      <= 5'd0;
         acc_r      <= {ACC_W{1'b0}};
         tag_r      <= {TAG_W{1'b0}};
         out_prod_r <= {(2*MANT_W){1'b0}};
         out_tag_r  <= {TAG_W{1'b0}};
      end else if (mult_flush) begin
         mreg_r     <= {MREG_W{1'b0}};
         cnt_r      <= 5'd0;
         acc_r      <= {ACC_W{1'b0}};
         out_prod_r <= {(2*MANT_W){1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (in_vld) begin
                  a54_r  <= {1'b0, in_src_a};
                  mreg_r <= {2'b00, in_src_b, 1'b0};
                  tag_r  <= in_tag;
                  cnt_r  <= 5'd0;
                  acc_r  <= {ACC_W{1'b0}};
               end
            end
            RUN: begin
               acc_r  <= acc_sum_s;
               mreg_r <= mreg_shift_s;
               cnt_r  <= cnt_r + GRP_CNT;
               if (last_s) begin
                  out_prod_r <= acc_sum_s[2*MANT_W-1:0];
                  out_tag_r  <= tag_r;
               end
            end
            default: begin
               acc_r <= acc_r;
            end
         endcase
      end
   end

   assign in_rdy   = (state_r == IDLE);
   assign out_vld  = (state_r == DONE);
   assign busy     = (state_r != IDLE);
   assign out_prod = out_prod_r;
   assign out_tag  = out_tag_r;

   vfmau_booth_iter_mult_ctrl_chk u_chk (
      .clk    (cpuclk),
      .rst_n  (cpurst_b),
      .done   (state_r == DONE),
      .acc_hi (acc_r[ACC_W-1 -: 2])
   );

endmodule

// File: tb/tb_vfmau_booth_iter_mult_ctrl.sv
// Directed bench for vfmau_booth_iter_mult_ctrl (GRP_PER_CYC=3); honours VFMAU_BOOTH_EARLY_TERM_EN.
module tb_vfmau_booth_iter_mult_ctrl;

   logic          cpuclk = 1'b0;
   logic          cpurst_b;
   logic          mult_flush;
   logic          in_vld;
   logic          in_rdy;
   logic [52:0]   in_src_a;
   logic [52:0]   in_src_b;
   logic [3:0]    in_tag;
   logic          out_vld;
   logic          out_rdy;
   logic [105:0]  out_prod;
   logic [3:0]    out_tag;
   logic          busy;

   int tests_run    = 0;
   int tests_failed = 0;

   localparam int LAT_FULL = 10;
`ifdef VFMAU_BOOTH_EARLY_TERM_EN
   localparam int LAT_SMALL = 2;
`else
   localparam int LAT_SMALL = 10;
`endif

   localparam logic [52:0]  ALL_ONES    = 53'h1F_FFFF_FFFF_FFFF;
   localparam logic [105:0] ALL_ONES_SQ = {52'hF_FFFF_FFFF_FFFF, 54'd1};

   vfmau_booth_iter_mult_ctrl #(.GRP_PER_CYC(3), .TAG_W(4)) dut (
      .cpuclk     (cpuclk),
      .cpurst_b   (cpurst_b),
      .mult_flush (mult_flush),
      .in_vld     (in_vld),
      .in_rdy     (in_rdy),
      .in_src_a   (in_src_a),
      .in_src_b   (in_src_b),
      .in_tag     (in_tag),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .out_prod   (out_prod),
      .out_tag    (out_tag),
      .busy       (busy)
   );

   always #5 cpuclk = ~cpuclk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [105:0] mul_ref(input logic [52:0] a, input logic [52:0] b);
      return {53'd0, a} * {53'd0, b};
   endfunction

   task automatic run_op(input string name, input logic [52:0] a, input logic [52:0] b,
                         input logic [3:0] t, input logic [105:0] exp_prod,
                         input int exp_lat, input int hold);
      int cyc;
      bit seen;
      check({name, "_in_rdy"}, 128'(in_rdy), 128'd1);
      in_src_a = a;
      in_src_b = b;
      in_tag   = t;
      in_vld   = 1'b1;
      @(posedge cpuclk);
      @(negedge cpuclk);
      in_vld = 1'b0;
      cyc    = 1;
      seen   = 1'b0;
      while (!seen && cyc < 40) begin
         if (out_vld) seen = 1'b1;
         else begin
            @(negedge cpuclk);
            cyc++;
         end
      end
      check({name, "_latency"}, 128'(cyc), 128'(exp_lat));
      check({name, "_prod"}, 128'(out_prod), 128'(exp_prod));
      check({name, "_tag"}, 128'(out_tag), 128'(t));
      check({name, "_acc_hi"}, 128'(dut.acc_r[107:106]), 128'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge cpuclk);
         check({name, "_hold_vld"}, 128'(out_vld), 128'd1);
         check({name, "_hold_prod"}, 128'(out_prod), 128'(exp_prod));
         check({name, "_hold_tag"}, 128'(out_tag), 128'(t));
         check({name, "_hold_in_rdy"}, 128'(in_rdy), 128'd0);
      end
      out_rdy = 1'b1;
      @(posedge cpuclk);
      @(negedge cpuclk);
      out_rdy = 1'b0;
      check({name, "_rel_vld"}, 128'(out_vld), 128'd0);
      check({name, "_rel_in_rdy"}, 128'(in_rdy), 128'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int cyc;
      bit seen;
      cpurst_b   = 1'b0;
      mult_flush = 1'b0;
      in_vld     = 1'b0;
      in_src_a   = 53'd0;
      in_src_b   = 53'd0;
      in_tag     = 4'h0;
      out_rdy    = 1'b0;
      repeat (2) @(negedge cpuclk);
      check("rst_in_rdy", 128'(in_rdy), 128'd1);
      check("rst_out_vld", 128'(out_vld), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_prod", 128'(out_prod), 128'd0);
      check("rst_tag", 128'(out_tag), 128'd0);
      cpurst_b = 1'b1;
      @(negedge cpuclk);

      run_op("one", 53'd1, 53'd1, 4'hA, 106'd1, LAT_SMALL, 0);
      run_op("allones", ALL_ONES, ALL_ONES, 4'h3, ALL_ONES_SQ, LAT_FULL, 0);
      run_op("alt", 53'h15_5555_5555_5555, 53'h0A_AAAA_AAAA_AAAA, 4'h5,
             mul_ref(53'h15_5555_5555_5555, 53'h0A_AAAA_AAAA_AAAA), LAT_FULL, 5);
      run_op("small", 53'd7, 53'd5, 4'h1, 106'd35, LAT_SMALL, 0);
      run_op("b_zero", 53'h123, 53'd0, 4'h2, 106'd0, LAT_SMALL, 0);
      run_op("a_zero", 53'd0, ALL_ONES, 4'h4, 106'd0, LAT_FULL, 0);
      run_op("b_msb", ALL_ONES, 53'h10_0000_0000_0000, 4'h6,
             {1'b0, ALL_ONES, 52'd0}, LAT_FULL, 0);

      // flush during RUN cycle 4 with a competing in_vld
      in_src_a = ALL_ONES;
      in_src_b = ALL_ONES;
      in_tag   = 4'h7;
      in_vld   = 1'b1;
      @(posedge cpuclk);
      @(negedge cpuclk);
      in_vld = 1'b0;
      repeat (3) @(negedge cpuclk);
      check("flush_busy_before", 128'(busy), 128'd1);
      mult_flush = 1'b1;
      in_vld     = 1'b1;
      in_src_a   = 53'd3;
      in_src_b   = 53'd3;
      @(posedge cpuclk);
      @(negedge cpuclk);
      mult_flush = 1'b0;
      in_vld     = 1'b0;
      check("flush_busy", 128'(busy), 128'd0);
      check("flush_in_rdy", 128'(in_rdy), 128'd1);
      check("flush_out_vld", 128'(out_vld), 128'd0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge cpuclk);
         if (out_vld) seen = 1'b1;
      end
      check("flush_no_result", 128'(seen), 128'd0);
      run_op("post_flush", 53'h0F_0F0F_0F0F_0F0F, 53'h13_579B_DF02_4680, 4'h8,
             mul_ref(53'h0F_0F0F_0F0F_0F0F, 53'h13_579B_DF02_4680), LAT_FULL, 0);

      // asynchronous reset in the middle of RUN
      in_src_a = ALL_ONES;
      in_src_b = ALL_ONES;
      in_tag   = 4'hC;
      in_vld   = 1'b1;
      @(posedge cpuclk);
      @(negedge cpuclk);
      in_vld = 1'b0;
      cyc = 1;
      while (cyc < 3) begin
         @(negedge cpuclk);
         cyc++;
      end
      cpurst_b = 1'b0;
      #1;
      check("midrst_in_rdy", 128'(in_rdy), 128'd1);
      check("midrst_out_vld", 128'(out_vld), 128'd0);
      check("midrst_busy", 128'(busy), 128'd0);
      check("midrst_prod", 128'(out_prod), 128'd0);
      check("midrst_tag", 128'(out_tag), 128'd0);
      @(negedge cpuclk);
      cpurst_b = 1'b1;
      @(negedge cpuclk);
      run_op("post_rst", 53'h1A_BCDE_F012_3456, 53'h07_6543_210F_EDCB, 4'hD,
             mul_ref(53'h1A_BCDE_F012_3456, 53'h07_6543_210F_EDCB), LAT_FULL, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
